// File: rtl/rc5_key_mix_if.sv
// RAM-side bus of the RC5 key-mixing stage: single-port synchronous S and L RAM interfaces.
// master = mixing engine, slave = RAM wrapper.
interface rc5_key_mix_if #(
    parameter int unsigned W        = 32,
    parameter int unsigned T_LENGTH = 4,
    parameter int unsigned C_LENGTH = 2
) ();
    logic [W-1:0]        iS_sub_i;
    logic [W-1:0]        oS_sub_i_prima;
    logic [T_LENGTH-1:0] oS_address;
    logic                oS_we;
    logic [W-1:0]        iL_sub_j;
    logic [W-1:0]        oL_sub_j_prima;
    logic [C_LENGTH-1:0] oL_address;
    logic                oL_we;

    modport master (
        input  iS_sub_i,
        input  iL_sub_j,
        output oS_sub_i_prima,
        output oS_address,
        output oS_we,
        output oL_sub_j_prima,
        output oL_address,
        output oL_we
    );

    modport slave (
        output iS_sub_i,
        output iL_sub_j,
        input  oS_sub_i_prima,
        input  oS_address,
        input  oS_we,
        input  oL_sub_j_prima,
        input  oL_address,
        input  oL_we
    );
endinterface

// File: rtl/rc5_key_mix.sv
// RC5 key-schedule mixing stage: 3*max(T,C) iterations over the S and L RAMs.
// Define RC5_KEY_MIX_FAST_READ_EN for combinational-read RAMs (4-cycle iterations).
module rc5_key_mix #(
    parameter int unsigned T        = 16,
    parameter int unsigned C        = 4,
    parameter int unsigned W        = 32,
    parameter int unsigned T_LENGTH = $clog2(T),
    parameter int unsigned C_LENGTH = (C > 1) ? $clog2(C) : 1,
    parameter int unsigned N        = 3 * ((T > C) ? T : C),
    parameter int unsigned K_LENGTH = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iStart,
    rc5_key_mix_if.master ramBus,
    output logic          oDone
);
    localparam int unsigned LOGW = $clog2(W);
    localparam logic [T_LENGTH-1:0] ILast = T_LENGTH'(T - 1);
    localparam logic [C_LENGTH-1:0] JLast = C_LENGTH'(C - 1);
    localparam logic [K_LENGTH-1:0] KLast = K_LENGTH'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetAddr,
        StWaitRead,
        StCalcA,
        StCalcB,
        StNext,
        StDone
    } state_e;

    state_e              stateQ, stateD;
    logic [W-1:0]        aQ, aD;
    logic [W-1:0]        bQ, bD;
    logic [W-1:0]        ljQ, ljD;
    logic [T_LENGTH-1:0] iQ, iD;
    logic [C_LENGTH-1:0] jQ, jD;
    logic [K_LENGTH-1:0] kQ, kD;
    logic [T_LENGTH-1:0] sAddrQ, sAddrD;
    logic [C_LENGTH-1:0] lAddrQ, lAddrD;
    logic [W-1:0]        sDataQ, sDataD;
    logic [W-1:0]        lDataQ, lDataD;
    logic                sWeQ, sWeD;
    logic                lWeQ, lWeD;
    logic                doneQ, doneD;

    logic [W-1:0] abSum;
    logic [W-1:0] sumA;
    logic [W-1:0] sumB;
    logic [W-1:0] aNew;
    logic [W-1:0] bNew;

    // Rotate via a doubled word so a zero amount passes the value through untouched.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LOGW-1:0] s);
        logic [2*W-1:0] dbl;
        dbl = {x, x} << s;
        return dbl[2*W-1:W];
    endfunction

    always_comb begin
        stateD = stateQ;
        aD     = aQ;
        bD     = bQ;
        ljD    = ljQ;
        iD     = iQ;
        jD     = jQ;
        kD     = kQ;
        sAddrD = sAddrQ;
        lAddrD = lAddrQ;
        sDataD = sDataQ;
        lDataD = lDataQ;
        sWeD   = sWeQ;
        lWeD   = lWeQ;
        doneD  = doneQ;

        abSum = aQ + bQ;
        sumA  = ramBus.iS_sub_i + aQ + bQ;
        sumB  = ljQ + abSum;
        aNew  = rotl(sumA, LOGW'(3));
        bNew  = rotl(sumB, abSum[LOGW-1:0]);

        case (stateQ)
            StIdle: begin
                if (iStart) begin
                    stateD = StSetAddr;
                end
            end
            StSetAddr: begin
                sAddrD = iQ;
                lAddrD = jQ;
                sWeD   = 1'b0;
                lWeD   = 1'b0;
`ifdef RC5_KEY_MIX_FAST_READ_EN
                stateD = StCalcA;
`else
                stateD = StWaitRead;
`endif
            end
            StWaitRead: begin
                stateD = StCalcA;
            end
            StCalcA: begin
                aD     = aNew;
                sDataD = aNew;
                sWeD   = 1'b1;
                ljD    = ramBus.iL_sub_j;
                stateD = StCalcB;
            end
            StCalcB: begin
                // aQ already holds the freshly mixed S[i] here.
                bD     = bNew;
                lDataD = bNew;
                sWeD   = 1'b0;
                lWeD   = 1'b1;
                stateD = StNext;
            end
            StNext: begin
                lWeD = 1'b0;
                iD   = (iQ == ILast) ? '0 : iQ + 1'b1;
                jD   = (jQ == JLast) ? '0 : jQ + 1'b1;
                if (kQ == KLast) begin
                    doneD  = 1'b1;
                    stateD = StDone;
                end else begin
                    kD     = kQ + 1'b1;
                    stateD = StSetAddr;
                end
            end
            StDone: begin
                sWeD  = 1'b0;
                lWeD  = 1'b0;
                doneD = 1'b1;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // Dropping iStart behaves exactly like rst; a partial table is abandoned.
    always_ff @(posedge clk) begin
        if (rst || !iStart) begin
            stateQ <= StIdle;
            aQ     <= '0;
            bQ     <= '0;
            ljQ    <= '0;
            iQ     <= '0;
            jQ     <= '0;
            kQ     <= '0;
            sAddrQ <= '0;
            lAddrQ <= '0;
            sDataQ <= '0;
            lDataQ <= '0;
            sWeQ   <= 1'b0;
            lWeQ   <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            aQ     <= aD;
            bQ     <= bD;
            ljQ    <= ljD;
            iQ     <= iD;
            jQ     <= jD;
            kQ     <= kD;
            sAddrQ <= sAddrD;
            lAddrQ <= lAddrD;
            sDataQ <= sDataD;
            lDataQ <= lDataD;
            sWeQ   <= sWeD;
            lWeQ   <= lWeD;
            doneQ  <= doneD;
        end
    end

    assign ramBus.oS_address     = sAddrQ;
    assign ramBus.oS_sub_i_prima = sDataQ;
    assign ramBus.oS_we          = sWeQ;
    assign ramBus.oL_address     = lAddrQ;
    assign ramBus.oL_sub_j_prima = lDataQ;
    assign ramBus.oL_we          = lWeQ;
    assign oDone                 = doneQ;

endmodule

// File: tb/tb_rc5_key_mix.sv
// Scoreboard bench for rc5_key_mix: RAM models, reference key schedule, write monitor.
module tb_rc5_key_mix;
    localparam int T = 16;
    localparam int C = 4;
    localparam int W = 32;
    localparam int N = 48;
`ifdef RC5_KEY_MIX_FAST_READ_EN
    localparam int LAT = 4 * N + 1;
`else
    localparam int LAT = 5 * N + 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic iStart;
    logic oDone;

    always #5 clk = ~clk;

    rc5_key_mix_if #(.W(W), .T_LENGTH(4), .C_LENGTH(2)) ramBus ();

    rc5_key_mix #(.T(T), .C(C), .W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .iStart (iStart),
        .ramBus (ramBus),
        .oDone  (oDone)
    );

    logic [31:0] sMem [T];
    logic [31:0] lMem [C];

`ifdef RC5_KEY_MIX_FAST_READ_EN
    assign ramBus.iS_sub_i = sMem[ramBus.oS_address];
    assign ramBus.iL_sub_j = lMem[ramBus.oL_address];
`else
    logic [31:0] sRd;
    logic [31:0] lRd;
    always @(posedge clk) begin
        sRd <= sMem[ramBus.oS_address];
        lRd <= lMem[ramBus.oL_address];
    end
    assign ramBus.iS_sub_i = sRd;
    assign ramBus.iL_sub_j = lRd;
`endif

    always @(posedge clk) begin
        if (ramBus.oS_we) sMem[ramBus.oS_address] <= ramBus.oS_sub_i_prima;
        if (ramBus.oL_we) lMem[ramBus.oL_address] <= ramBus.oL_sub_j_prima;
    end

    typedef struct {
        bit          isL;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         expQ[$];
    logic [31:0] sInit [T];
    logic [31:0] lInit [C];
    logic [31:0] expS  [T];
    int          checks = 0;
    int          failures = 0;
    int          sWrites = 0;
    int          lWrites = 0;
    int          sBase = 0;
    int          lBase = 0;
    bit          firstCheck = 1'b0;
    bit          prevS = 1'b0;
    bit          prevL = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
        int s;
        s = r % 32;
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    // Reference key schedule straight from the mixing equations.
    task automatic build_expect();
        logic [31:0] s [T];
        logic [31:0] l [C];
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ab;
        wr_t         w;
        s = sInit;
        l = lInit;
        a = 0;
        b = 0;
        expQ.delete();
        for (int k = 0; k < N; k++) begin
            int i = k % T;
            int j = k % C;
            a = rotl(s[i] + a + b, 3);
            s[i] = a;
            w.isL = 1'b0; w.addr = i; w.data = a;
            expQ.push_back(w);
            ab = a + b;
            b = rotl(l[j] + ab, int'(ab & 32'd31));
            l[j] = b;
            w.isL = 1'b1; w.addr = j; w.data = b;
            expQ.push_back(w);
        end
        expS = s;
    endtask

    task automatic check_write(input bit isL, input int addr, input logic [31:0] data,
                               input bit prevWe, input int count);
        wr_t e;
        checks++;
        if (prevWe) begin
            failures++;
            $display("FAIL we_pulse_width isL=%0d actual=2+cycles required=1", isL);
        end
        if (firstCheck && count == 0) begin
            check(isL ? "first_l_write" : "first_s_write", data,
                  isL ? 32'hB7E15163 : 32'hBF0A8B1D);
        end
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write isL=%0d actual_addr=%0d actual_data=%h required=none",
                     isL, addr, data);
        end else begin
            e = expQ.pop_front();
            if (e.isL != isL || e.addr != addr || e.data !== data) begin
                failures++;
                $display("FAIL write actual=(isL=%0d addr=%0d data=%h) required=(isL=%0d addr=%0d data=%h)",
                         isL, addr, data, e.isL, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (ramBus.oS_we && ramBus.oL_we) begin
            check("simultaneous_we", 32'd1, 32'd0);
        end
        if (ramBus.oS_we) begin
            check_write(1'b0, int'(ramBus.oS_address), ramBus.oS_sub_i_prima, prevS,
                        sWrites - sBase);
            sWrites++;
        end
        if (ramBus.oL_we) begin
            check_write(1'b1, int'(ramBus.oL_address), ramBus.oL_sub_j_prima, prevL,
                        lWrites - lBase);
            lWrites++;
        end
        prevS <= ramBus.oS_we;
        prevL <= ramBus.oL_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restore();
        sMem = sInit;
        lMem = lInit;
    endtask

    task automatic load(input bit spec);
        for (int i = 0; i < T; i++) begin
            sInit[i] = spec ? 32'hB7E15163 + 32'(i) * 32'h9E3779B9 : $urandom;
        end
        for (int j = 0; j < C; j++) begin
            lInit[j] = spec ? 32'd0 : $urandom;
        end
        restore();
    endtask

    // Called right after an edge with the DUT held in reset; that edge is edge 0.
    task automatic start_run();
        build_expect();
        sBase = sWrites;
        lBase = lWrites;
        rst = 1'b0;
        iStart = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_s_we"}, 32'(ramBus.oS_we), 32'd0);
        check({tag, "_l_we"}, 32'(ramBus.oL_we), 32'd0);
        check({tag, "_done"}, 32'(oDone), 32'd0);
        check({tag, "_s_addr"}, 32'(ramBus.oS_address), 32'd0);
        check({tag, "_l_addr"}, 32'(ramBus.oL_address), 32'd0);
        check({tag, "_s_data"}, ramBus.oS_sub_i_prima, 32'd0);
        check({tag, "_l_data"}, ramBus.oL_sub_j_prima, 32'd0);
    endtask

    task automatic finish_run(input string tag);
        int cyc = 0;
        while (cyc < LAT + 20) begin
            tick();
            cyc++;
            if (oDone) break;
        end
        check({tag, "_done_edge"}, 32'(cyc), 32'(LAT));
        check({tag, "_s_writes"}, 32'(sWrites - sBase), 32'(N));
        check({tag, "_l_writes"}, 32'(lWrites - lBase), 32'(N));
        check({tag, "_queue_left"}, 32'(expQ.size()), 32'd0);
        for (int i = 0; i < T; i++) begin
            check($sformatf("%s_final_s%0d", tag, i), sMem[i], expS[i]);
        end
    endtask

    task automatic done_hold(input string tag);
        repeat (20) begin
            tick();
            check({tag, "_hold_done"}, 32'(oDone), 32'd1);
            check({tag, "_hold_s_we"}, 32'(ramBus.oS_we), 32'd0);
            check({tag, "_hold_l_we"}, 32'(ramBus.oL_we), 32'd0);
        end
    endtask

    task automatic stop_run(input string tag);
        iStart = 1'b0;
        tick();
        check_idle(tag);
    endtask

    task automatic wait_l(input int n, input string tag);
        int cyc = 0;
        while (lWrites - lBase < n && cyc < LAT) begin
            tick();
            cyc++;
        end
        check({tag, "_reached_iter"}, 32'(lWrites - lBase >= n), 32'd1);
    endtask

    task automatic quiet(input string tag);
        repeat (4) begin
            tick();
            check({tag, "_quiet_s_we"}, 32'(ramBus.oS_we), 32'd0);
            check({tag, "_quiet_l_we"}, 32'(ramBus.oL_we), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        iStart = 1'b0;
        repeat (3) tick();
        check_idle("por");

        // All-zero key over the initialiser's S table.
        firstCheck = 1'b1;
        load(1'b1);
        start_run();
        finish_run("spec");
        firstCheck = 1'b0;
        done_hold("spec");
        stop_run("spec_stop");

        for (int r = 0; r < 2; r++) begin
            load(1'b0);
            start_run();
            finish_run($sformatf("rand%0d", r));
            stop_run($sformatf("rand%0d_stop", r));
        end

        // rst mid-run with iStart still high.
        load(1'b0);
        start_run();
        wait_l(7, "rst_mid");
        rst = 1'b1;
        tick();
        expQ.delete();
        check_idle("rst_mid");
        quiet("rst_mid");
        restore();
        start_run();
        finish_run("rst_restart");
        stop_run("rst_restart_stop");

        // iStart dropped at iteration 10.
        load(1'b0);
        start_run();
        wait_l(10, "drop");
        iStart = 1'b0;
        tick();
        expQ.delete();
        check_idle("drop");
        quiet("drop");
        restore();
        start_run();
        finish_run("drop_restart");
        done_hold("drop_restart");
        stop_run("drop_restart_stop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
